multicycle_controller: RTL and testbench

- Sequencing control FSM for the multi-cycle MIPS datapath (shared instruction/data memory, IR, A/B/ALUOut registers).
- Each cycle it drives the datapath multiplexer selects, register/PC/IR write enables and the ALU operation, one instruction phase at a time.
- It handshakes with the unified memory so fetches and data accesses can stretch over wait cycles.
- Instruction set: lw, sw, R-type (and, or, add, sub, slt, mul), addi, beq, j.

---
 rtl/multicycle_controller.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle MIPS datapath: one instruction phase per state,
// with memory phases stretched by the MemReady handshake.
module multicycle_controller (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCEn,
    output logic [1:0] PCSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       IllegalOp,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     state_q;
    state_t     state_d;
    logic       funct_ok;
    logic [2:0] funct_alu;
    logic       illegal;

    // R-type function decode; funct_ok also gates entry into EXEC
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = 3'b010;
        case (Funct)
            6'b100100: funct_alu = 3'b000;
            6'b100101: funct_alu = 3'b001;
            6'b100000: funct_alu = 3'b010;
            6'b100010: funct_alu = 3'b100;
            6'b101010: funct_alu = 3'b110;
            6'b011100: funct_alu = 3'b101;
            default:   funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_d = FETCH;
        illegal = 1'b0;
        case (state_q)
            FETCH:  state_d = MemReady ? DECODE : FETCH;
            DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE: begin
                        state_d = funct_ok ? EXEC : FETCH;
                        illegal = !funct_ok;
                    end
                    OP_ADDI: state_d = ADDIEX;
                    OP_BEQ:  state_d = BRANCH;
                    OP_J:    state_d = JUMP;
                    default: illegal = 1'b1;
                endcase
            end
            MEMADR: state_d = (Op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  state_d = MemReady ? MEMWB : MEMRD;
            MEMWR:  state_d = MemReady ? FETCH : MEMWR;
            EXEC:   state_d = ALUWB;
            ADDIEX: state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state_q <= FETCH;
        else     state_q <= state_d;
    end

    // Strobes are killed while RST is high so an interrupted write never lands
    always_comb begin
        MemReq     = 1'b0;
        MemWrite   = 1'b0;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        PCEn       = 1'b0;
        PCSrc      = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 3'b000;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        IllegalOp  = 1'b0;
        case (state_q)
            FETCH: begin
                MemReq     = 1'b1;
                ALUSrcB    = 2'b01;
                ALUControl = 3'b010;
                IRWrite    = MemReady;
                PCEn       = MemReady;
            end
            DECODE: begin
                ALUSrcB    = 2'b11;
                ALUControl = 3'b010;
                IllegalOp  = illegal;
            end
            MEMADR, ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = 3'b010;
            end
            MEMRD: begin
                MemReq = 1'b1;
                IorD   = 1'b1;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            MEMWR: begin
                MemReq   = 1'b1;
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            EXEC: begin
                ALUSrcA    = 1'b1;
                ALUControl = funct_alu;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            ADDIWB: RegWrite = 1'b1;
            BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = 3'b100;
                PCSrc      = 2'b01;
                PCEn       = Zero;
            end
            JUMP: begin
                PCSrc = 2'b10;
                PCEn  = 1'b1;
            end
            default: ;
        endcase
        if (RST) begin
            MemReq    = 1'b0;
            MemWrite  = 1'b0;
            IRWrite   = 1'b0;
            PCEn      = 1'b0;
            RegWrite  = 1'b0;
            IllegalOp = 1'b0;
        end
    end

    assign State = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a per-instruction vector table plus
// hand-written sequences for reset, memory wait states and an aborted store.
module tb_multicycle_controller;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [5:0] Op = 6'd0;
    logic [5:0] Funct = 6'd0;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b0;
    logic       MemReq, MemWrite, IorD, IRWrite, PCEn, ALUSrcA, RegDst, MemtoReg, RegWrite, IllegalOp;
    logic [1:0] PCSrc, ALUSrcB;
    logic [2:0] ALUControl;
    logic [3:0] State;

    int checks = 0;
    int failures = 0;

    multicycle_controller dut (
        .CLK(CLK), .RST(RST), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
        .MemReq(MemReq), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite), .PCEn(PCEn),
        .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .IllegalOp(IllegalOp),
        .State(State)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        int         cycles;
        logic [2:0] alu;
        int         regwr;
        logic       regdst;
        logic       memtoreg;
        int         memwr;
        int         pcen;
        logic [1:0] pcsrc;
        int         illegal;
        int         irwr;
    } vec_t;

    vec_t vecs[14];

    // Drive one cycle's inputs on the falling edge and let outputs settle
    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] funct,
                                 input logic zero, input logic mem_ready, input logic rst);
        @(negedge CLK);
        Op = op;
        Funct = funct;
        Zero = zero;
        MemReady = mem_ready;
        RST = rst;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic reset_dut();
        applyStimulus(6'd0, 6'd0, 1'b0, 1'b0, 1'b1);
        applyStimulus(6'd0, 6'd0, 1'b0, 1'b0, 1'b1);
        @(posedge CLK);
        #1;
    endtask

    // Called mid-cycle; advances with MemReady=1 until State reads FETCH after an edge
    task automatic wait_fetch(input string name);
        bit reached = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK);
            #1;
            if (State == 4'd0) begin
                reached = 1;
                break;
            end
            applyStimulus(Op, Funct, Zero, 1'b1, 1'b0);
        end
        checkOutput(name, {31'd0, reached}, 32'd1);
        if (!reached) reset_dut();
    endtask

    // Runs one instruction from FETCH with MemReady=1 and tallies what it did
    task automatic run_instr(input int idx);
        int cycles = 0, regwr = 0, memwr = 0, pcen = 0, illegal = 0, irwr = 0;
        logic [2:0] alu = 3'b111;
        logic regdst = 1'b0, memtoreg = 1'b0;
        logic [1:0] pcsrc = 2'b11;
        string tag;
        tag = $sformatf("v%0d", idx);
        for (int c = 0; c < 20; c++) begin
            applyStimulus(vecs[idx].op, vecs[idx].funct, vecs[idx].zero, 1'b1, 1'b0);
            if (State == 4'd6) alu = ALUControl;
            if (RegWrite) begin
                regwr++;
                regdst = RegDst;
                memtoreg = MemtoReg;
            end
            if (MemWrite && MemReq) memwr++;
            if (IllegalOp) illegal++;
            if (IRWrite) irwr++;
            if (PCEn && State != 4'd0) begin
                pcen++;
                pcsrc = PCSrc;
            end
            cycles++;
            @(posedge CLK);
            #1;
            if (State == 4'd0) break;
        end
        checkOutput({tag, "_cycles"}, cycles, vecs[idx].cycles);
        checkOutput({tag, "_exec_alu"}, {29'd0, alu}, {29'd0, vecs[idx].alu});
        checkOutput({tag, "_regwrite"}, regwr, vecs[idx].regwr);
        checkOutput({tag, "_regdst"}, {31'd0, regdst}, {31'd0, vecs[idx].regdst});
        checkOutput({tag, "_memtoreg"}, {31'd0, memtoreg}, {31'd0, vecs[idx].memtoreg});
        checkOutput({tag, "_memwrite"}, memwr, vecs[idx].memwr);
        checkOutput({tag, "_pcen"}, pcen, vecs[idx].pcen);
        checkOutput({tag, "_pcsrc"}, {30'd0, pcsrc}, {30'd0, vecs[idx].pcsrc});
        checkOutput({tag, "_illegal"}, illegal, vecs[idx].illegal);
        checkOutput({tag, "_irwrite"}, irwr, vecs[idx].irwr);
        if (State != 4'd0) reset_dut();
    endtask

    initial begin
        logic       lw_ready[7];
        logic [3:0] lw_state[7];

        //            op         funct      z     cyc alu     rw rd    m2r   mw pc pcsrc  ill irw
        vecs[0]  = '{6'b100011, 6'b000000, 1'b0, 5, 3'b111, 1, 1'b0, 1'b1, 0, 0, 2'b11, 0, 1};
        vecs[1]  = '{6'b101011, 6'b000000, 1'b0, 4, 3'b111, 0, 1'b0, 1'b0, 1, 0, 2'b11, 0, 1};
        vecs[2]  = '{6'b000000, 6'b100000, 1'b0, 4, 3'b010, 1, 1'b1, 1'b0, 0, 0, 2'b11, 0, 1};
        vecs[3]  = '{6'b000000, 6'b100010, 1'b0, 4, 3'b100, 1, 1'b1, 1'b0, 0, 0, 2'b11, 0, 1};
        vecs[4]  = '{6'b000000, 6'b101010, 1'b0, 4, 3'b110, 1, 1'b1, 1'b0, 0, 0, 2'b11, 0, 1};
        vecs[5]  = '{6'b000000, 6'b011100, 1'b0, 4, 3'b101, 1, 1'b1, 1'b0, 0, 0, 2'b11, 0, 1};
        vecs[6]  = '{6'b000000, 6'b100100, 1'b0, 4, 3'b000, 1, 1'b1, 1'b0, 0, 0, 2'b11, 0, 1};
        vecs[7]  = '{6'b000000, 6'b100101, 1'b0, 4, 3'b001, 1, 1'b1, 1'b0, 0, 0, 2'b11, 0, 1};
        vecs[8]  = '{6'b001000, 6'b000000, 1'b0, 4, 3'b111, 1, 1'b0, 1'b0, 0, 0, 2'b11, 0, 1};
        vecs[9]  = '{6'b000100, 6'b000000, 1'b1, 3, 3'b111, 0, 1'b0, 1'b0, 0, 1, 2'b01, 0, 1};
        vecs[10] = '{6'b000100, 6'b000000, 1'b0, 3, 3'b111, 0, 1'b0, 1'b0, 0, 0, 2'b11, 0, 1};
        vecs[11] = '{6'b000010, 6'b000000, 1'b0, 3, 3'b111, 0, 1'b0, 1'b0, 0, 1, 2'b10, 0, 1};
        vecs[12] = '{6'b111111, 6'b000000, 1'b0, 2, 3'b111, 0, 1'b0, 1'b0, 0, 0, 2'b11, 1, 1};
        vecs[13] = '{6'b000000, 6'b000000, 1'b0, 2, 3'b111, 0, 1'b0, 1'b0, 0, 0, 2'b11, 1, 1};

        reset_dut();
        checkOutput("reset_state", {28'd0, State}, 32'd0);

        // Reset asserted for two cycles starting in EXEC
        applyStimulus(6'b000000, 6'b100000, 1'b0, 1'b1, 1'b0);
        applyStimulus(6'b000000, 6'b100000, 1'b0, 1'b1, 1'b0);
        applyStimulus(6'b000000, 6'b100000, 1'b0, 1'b1, 1'b1);
        checkOutput("rst_in_exec_state", {28'd0, State}, 32'd6);
        checkOutput("rst_in_exec_regwrite", {31'd0, RegWrite}, 32'd0);
        applyStimulus(6'b000000, 6'b100000, 1'b0, 1'b1, 1'b1);
        checkOutput("rst_state", {28'd0, State}, 32'd0);
        checkOutput("rst_memreq", {31'd0, MemReq}, 32'd0);
        checkOutput("rst_irwrite", {31'd0, IRWrite}, 32'd0);
        checkOutput("rst_pcen", {31'd0, PCEn}, 32'd0);
        checkOutput("rst_alusrcb", {30'd0, ALUSrcB}, 32'd1);
        applyStimulus(6'b000000, 6'b100000, 1'b0, 1'b0, 1'b0);
        checkOutput("fetch_wait_state", {28'd0, State}, 32'd0);
        checkOutput("fetch_wait_memreq", {31'd0, MemReq}, 32'd1);
        checkOutput("fetch_wait_irwrite", {31'd0, IRWrite}, 32'd0);
        applyStimulus(6'b000000, 6'b100000, 1'b0, 1'b1, 1'b0);
        checkOutput("first_fetch_state", {28'd0, State}, 32'd0);
        checkOutput("first_fetch_irwrite", {31'd0, IRWrite}, 32'd1);
        checkOutput("first_fetch_pcen", {31'd0, PCEn}, 32'd1);
        wait_fetch("post_reset_return");

        for (int i = 0; i < 14; i++) run_instr(i);

        // lw with two wait cycles in MEMRD; MemReady low in DECODE/MEMADR is ignored
        lw_ready = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        lw_state = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
        for (int i = 0; i < 7; i++) begin
            applyStimulus(6'b100011, 6'd0, 1'b0, lw_ready[i], 1'b0);
            checkOutput($sformatf("lw_wait_state%0d", i), {28'd0, State}, {28'd0, lw_state[i]});
            checkOutput($sformatf("lw_wait_regwrite%0d", i), {31'd0, RegWrite}, (i == 6) ? 32'd1 : 32'd0);
            checkOutput($sformatf("lw_wait_memtoreg%0d", i), {31'd0, MemtoReg}, (i == 6) ? 32'd1 : 32'd0);
            if (lw_state[i] == 4'd3)
                checkOutput($sformatf("lw_wait_memreq_iord%0d", i), {30'd0, MemReq, IorD}, 32'd3);
        end
        @(posedge CLK);
        #1;
        checkOutput("lw_wait_end_state", {28'd0, State}, 32'd0);

        // sw interrupted by reset while waiting on memory
        applyStimulus(6'b101011, 6'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(6'b101011, 6'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(6'b101011, 6'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(6'b101011, 6'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("sw_wait_state", {28'd0, State}, 32'd5);
        checkOutput("sw_wait_strobes", {29'd0, MemReq, MemWrite, IorD}, 32'd7);
        applyStimulus(6'b101011, 6'd0, 1'b0, 1'b1, 1'b1);
        checkOutput("sw_rst_state", {28'd0, State}, 32'd5);
        checkOutput("sw_rst_memwrite", {31'd0, MemWrite}, 32'd0);
        checkOutput("sw_rst_memreq", {31'd0, MemReq}, 32'd0);
        applyStimulus(6'b101011, 6'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("sw_after_rst_state", {28'd0, State}, 32'd0);
        checkOutput("sw_after_rst_memwrite", {31'd0, MemWrite}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
